// File: rtl/arm7tdmi_jtag_tap_gen.sv
// arm7tdmi_jtag_tap_gen: parametrised IEEE 1149.1 TAP controller.
// Provides the 16-state TAP FSM, an IR of IR_LEN bits, the internal BYPASS
// and IDCODE data registers, and one-hot selects for NUM_EXT external chains.
// Optional macro TAP_IDCODE_EN: when defined, the 32-bit IDCODE DR is built
// and reset/TLR load IDCODE_INS. When undefined, there is no IDCODE DR,
// IDCODE_INS decodes as BYPASS, and reset/TLR load BYPASS_INS.
module arm7tdmi_jtag_tap_gen #(
  parameter int                IR_LEN     = 4,
  parameter logic [31:0]       IDCODE_VAL = 32'h0F0F0F0F,
  parameter int                NUM_EXT    = 2,
  parameter logic [IR_LEN-1:0] IDCODE_INS = {{(IR_LEN-1){1'b1}}, 1'b0},
  parameter logic [IR_LEN-1:0] BYPASS_INS = {IR_LEN{1'b1}}
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               tms,
  input  logic               tdi,
  output logic               tdo,
  output logic               tdo_en,
  output logic [3:0]         tap_state,
  output logic               test_logic_reset,
  output logic               run_test_idle,
  output logic               capture_dr,
  output logic               shift_dr,
  output logic               update_dr,
  output logic               capture_ir,
  output logic               shift_ir,
  output logic               update_ir,
  output logic [IR_LEN-1:0]  current_ir,
  output logic [NUM_EXT-1:0] ext_select,
  input  logic [NUM_EXT-1:0] ext_tdo
);

  localparam logic [3:0] S_TLR   = 4'hF;
  localparam logic [3:0] S_RTI   = 4'hC;
  localparam logic [3:0] S_SELDR = 4'h7;
  localparam logic [3:0] S_CAPDR = 4'h6;
  localparam logic [3:0] S_SHDR  = 4'h2;
  localparam logic [3:0] S_EX1DR = 4'h1;
  localparam logic [3:0] S_PADR  = 4'h3;
  localparam logic [3:0] S_EX2DR = 4'h0;
  localparam logic [3:0] S_UPDDR = 4'h5;
  localparam logic [3:0] S_SELIR = 4'h4;
  localparam logic [3:0] S_CAPIR = 4'hE;
  localparam logic [3:0] S_SHIR  = 4'hA;
  localparam logic [3:0] S_EX1IR = 4'h9;
  localparam logic [3:0] S_PAIR  = 4'hB;
  localparam logic [3:0] S_EX2IR = 4'h8;
  localparam logic [3:0] S_UPDIR = 4'hD;

`ifdef TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_IR = IDCODE_INS;
`else
  localparam logic [IR_LEN-1:0] RST_IR = BYPASS_INS;
`endif

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

  logic [3:0]        nxt_state;
  logic [IR_LEN-1:0] ir_sr;
  logic              bypass_sr;
  logic              ins_bypass;
  logic              ins_idcode;
  logic              ext_any;
  logic              ext_bit;

  // Next-state logic: standard 1149.1 transitions on tms
  always_comb begin
    nxt_state = S_TLR;
    case (tap_state)
      S_TLR:   nxt_state = tms ? S_TLR   : S_RTI;
      S_RTI:   nxt_state = tms ? S_SELDR : S_RTI;
      S_SELDR: nxt_state = tms ? S_SELIR : S_CAPDR;
      S_CAPDR: nxt_state = tms ? S_EX1DR : S_SHDR;
      S_SHDR:  nxt_state = tms ? S_EX1DR : S_SHDR;
      S_EX1DR: nxt_state = tms ? S_UPDDR : S_PADR;
      S_PADR:  nxt_state = tms ? S_EX2DR : S_PADR;
      S_EX2DR: nxt_state = tms ? S_UPDDR : S_SHDR;
      S_UPDDR: nxt_state = tms ? S_SELDR : S_RTI;
      S_SELIR: nxt_state = tms ? S_TLR   : S_CAPIR;
      S_CAPIR: nxt_state = tms ? S_EX1IR : S_SHIR;
      S_SHIR:  nxt_state = tms ? S_EX1IR : S_SHIR;
      S_EX1IR: nxt_state = tms ? S_UPDIR : S_PAIR;
      S_PAIR:  nxt_state = tms ? S_EX2IR : S_PAIR;
      S_EX2IR: nxt_state = tms ? S_UPDIR : S_SHIR;
      S_UPDIR: nxt_state = tms ? S_SELDR : S_RTI;
      default: nxt_state = S_TLR;
    endcase
  end

  // State register
  always_ff @(posedge tck) begin
    if (trst) tap_state <= S_TLR;
    else      tap_state <= nxt_state;
  end

  // IR shift register: capture 0..01, shift right with tdi into the MSB
  always_ff @(posedge tck) begin
    if (trst)                    ir_sr <= '0;
    else if (tap_state == S_CAPIR) ir_sr <= IR_CAPTURE;
    else if (tap_state == S_SHIR)  ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};
  end

  // Active instruction: only UpdIR commits, so an aborted shift never lands
  always_ff @(posedge tck) begin
    if (trst)                      current_ir <= RST_IR;
    else if (tap_state == S_TLR)   current_ir <= RST_IR;
    else if (tap_state == S_UPDIR) current_ir <= ir_sr;
  end

  // Instruction decode, BYPASS first then IDCODE then external chains
  assign ins_bypass = (current_ir == BYPASS_INS);
`ifdef TAP_IDCODE_EN
  assign ins_idcode = !ins_bypass && (current_ir == IDCODE_INS);
`else
  assign ins_idcode = 1'b0;
`endif

  for (genvar k = 0; k < NUM_EXT; k++) begin : g_ext
    assign ext_select[k] = (current_ir == IR_LEN'(k)) &&
                           (current_ir != BYPASS_INS) &&
                           (current_ir != IDCODE_INS);
  end

  assign ext_any = |ext_select;
  assign ext_bit = |(ext_select & ext_tdo);

  // BYPASS DR: cleared on capture, follows tdi while shifting
  always_ff @(posedge tck) begin
    if (trst) bypass_sr <= 1'b0;
    else if (!ext_any && !ins_idcode) begin
      if (tap_state == S_CAPDR)     bypass_sr <= 1'b0;
      else if (tap_state == S_SHDR) bypass_sr <= tdi;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_sr;

  // IDCODE DR: load the ID on capture, shift right with tdi into bit 31
  always_ff @(posedge tck) begin
    if (trst) idcode_sr <= '0;
    else if (ins_idcode) begin
      if (tap_state == S_CAPDR)     idcode_sr <= IDCODE_VAL;
      else if (tap_state == S_SHDR) idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end
`endif

  // tdo mux: selected register LSB while shifting, otherwise 0
  always_comb begin
    tdo = 1'b0;
    if (tap_state == S_SHIR) tdo = ir_sr[0];
    else if (tap_state == S_SHDR) begin
      if (ext_any) tdo = ext_bit;
`ifdef TAP_IDCODE_EN
      else if (ins_idcode) tdo = idcode_sr[0];
`endif
      else tdo = bypass_sr;
    end
  end

  assign tdo_en           = (tap_state == S_SHDR) || (tap_state == S_SHIR);
  assign test_logic_reset = (tap_state == S_TLR);
  assign run_test_idle    = (tap_state == S_RTI);
  assign capture_dr       = (tap_state == S_CAPDR);
  assign shift_dr         = (tap_state == S_SHDR);
  assign update_dr        = (tap_state == S_UPDDR);
  assign capture_ir       = (tap_state == S_CAPIR);
  assign shift_ir         = (tap_state == S_SHIR);
  assign update_ir        = (tap_state == S_UPDIR);

endmodule

// File: doc/arm7tdmi_jtag_tap_gen.md
Name: arm7tdmi_jtag_tap_gen

Overview:
Parametrised IEEE 1149.1 TAP controller, successor to the fixed 4-bit arm7tdmi_jtag_tap. Provides a configurable IR length and IDCODE value, internal BYPASS and IDCODE data registers, and NUM_EXT external data-register chains, each with its own select/tdo pair. It sits between the JTAG pins and the EmbeddedICE/scan-chain logic, and exports the decoded TAP state strobes.

Parameters:
IR_LEN, 4, instruction register width (>=2)
IDCODE_VAL, 32'h0F0F0F0F, value captured by the IDCODE DR; bit 0 must be 1
NUM_EXT, 2, number of external DR chains (1..2**IR_LEN-2)
IDCODE_INS, {IR_LEN{1'b1}} with bit 0 cleared (4'b1110), IDCODE opcode
BYPASS_INS, all ones, BYPASS opcode

Ports:
tck  in  1  TAP clock; all state changes on the rising edge
trst  in  1  synchronous active-high reset
tms  in  1  test mode select
tdi  in  1  test data in
tdo  out  1  test data out, combinational from the selected register LSB
tdo_en  out  1  high in Shift-DR or Shift-IR
tap_state  out  4  current state, 1149.1 encoding
test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir  out  1 each  one-hot state decodes
current_ir  out  IR_LEN  active instruction
ext_select  out  NUM_EXT  one-hot external chain select
ext_tdo  in  NUM_EXT  serial outputs of the external chains

Behaviour:
- Reset is synchronous, sampled on the rising edge of tck:
  - tap_state=TLR (4'hF)
  - current_ir=IDCODE_INS
  - IR and DR shift registers cleared
  - ext_select=0, tdo_en=0
- Test-Logic-Reset also loads current_ir=IDCODE_INS on every cycle spent in it.
- FSM: the 16 standard 1149.1 states, transitions on tms at the tck rising edge. Encoding:
  - TLR=F, RTI=C
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PaDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PaIR=B, Ex2IR=8, UpdIR=D
- Five consecutive tms=1 reach TLR from any state.
- IR path:
  - CapIR loads the IR shift register with {zeros, 2'b01}.
  - ShIR shifts right one bit per cycle, with tdi entering at the MSB.
  - UpdIR copies the shift register to current_ir.
  - current_ir is stable in every other state.
- Instruction decode (priority order):
  1. BYPASS_INS selects BYPASS.
  2. IDCODE_INS selects IDCODE.
  3. A value k < NUM_EXT asserts ext_select[k].
  4. Any other value selects BYPASS.
  ext_select is driven from current_ir only, so it stays stable through a DR scan.
- BYPASS DR: 1 bit, cleared at CapDR; in ShDR it loads tdi.
- IDCODE DR: 32 bits, loaded with IDCODE_VAL at CapDR; in ShDR it shifts right with tdi entering bit 31.
- External chains: this block only selects them; the chain owner uses capture_dr, shift_dr and update_dr.
- tdo value:
  - ShIR: IR shift register bit 0.
  - ShDR: bit 0 of the selected internal DR, or ext_tdo[k] for a selected external chain.
  - Any other state: 0.
- Timing: the first captured bit appears on tdo in the first ShDR/ShIR cycle, with no extra latency. Exit1 is entered on the cycle that shifts the last bit.
- Pause states hold all shift-register contents; Ex2 returns to Shift without recapturing.
- Reset asserted mid-scan:
  - The state goes to TLR on that edge.
  - A partial IR shift is discarded and never reaches current_ir.
  - Strobes deassert on that edge.

Optional Feature:
Macro TAP_IDCODE_EN.
- Defined: IDCODE DR is present; reset and TLR load IDCODE_INS.
- Undefined:
  - No IDCODE register is built.
  - IDCODE_INS decodes as BYPASS.
  - Reset and TLR load BYPASS_INS into current_ir.
  - A DR scan after reset yields a leading 0.

Test Plan:
- Reset with trst=1 for 5 cycles -> tap_state=4'hF, current_ir=4'b1110, tdo_en=0. Then tms=1 for 5 cycles from ShDR -> TLR.
- IR scan shifting in 4'b1111 (LSB first) -> tdo sequence 1,0,0,0 (capture 0001). After UpdIR: current_ir=4'b1111, ext_select=0.
- IDCODE scan with tdi=0 for 32 bits -> tdo bits equal IDCODE_VAL LSB first (first bit 1). A Pause-DR inserted after bit 10 for 3 cycles -> sequence unchanged.
- BYPASS scan with tdi pattern 0,1,0,1,1 -> tdo sequence 0,0,1,0,1 (one-cycle delay, leading captured 0).
- current_ir=4'b0001 with NUM_EXT=2 -> ext_select=2'b10 and tdo follows ext_tdo[1] in ShDR. current_ir=4'b0101 -> falls back to BYPASS.
- trst pulsed at IR shift bit 2 of a 4'b0000 load -> TLR on the next edge, current_ir=IDCODE_INS, and 4'b0000 is never applied.
